fetch_seq: RTL and testbench

Fetch sequencer for the instruction-fetch unit: owns the program counter, requests instruction words from instruction memory over a req/ack handshake, and hands each fetched instruction to decode over a valid/ready handshake. Next-PC selection is evaluated only when decode accepts an instruction, using jr / jal / branch / sequential priority. A misaligned or out-of-range next PC stops fetch and raises a sticky fault. It sits between the PC/IM datapath and the decode stage of the multi-cycle CPU.

---
 rtl/fetch_seq_if.sv | 36 +++
 rtl/fetch_seq.sv | 89 ++++++++
 tb/tb_fetch_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus: instruction-memory request side, decode handoff side,
// next-PC select inputs and the sequencer's debug state.
interface fetch_seq_if #(
  parameter int IM_AW = 12
);
  // Handshakes: imReq/imAddr are held until the cycle imAck=1, and imAck is
  // ignored while imReq=0. instrValid/instr/pc are held until the cycle
  // instrReady=1, and only that cycle transfers the instruction and samples the selects.
  logic             imReq;
  logic [IM_AW-1:0] imAddr;
  logic             imAck;
  logic [31:0]      imRd;
  logic [31:0]      instr;
  logic             instrValid;
  logic             instrReady;
  logic             branchSel;
  logic             jalSel;
  logic             jrSel;
  logic [31:0]      pcOffset;
  logic [25:0]      jalIndex;
  logic [31:0]      jrPc;
  logic [31:0]      pc;
  logic [31:0]      pc4;
  logic             fault;
  logic [1:0]       state_dbg;

  modport master (
    output imReq, imAddr, instr, instrValid, pc, pc4, fault, state_dbg,
    input  imAck, imRd, instrReady, branchSel, jalSel, jrSel, pcOffset, jalIndex, jrPc
  );

  modport slave (
    input  imReq, imAddr, instr, instrValid, pc, pc4, fault, state_dbg,
    output imAck, imRd, instrReady, branchSel, jalSel, jrSel, pcOffset, jalIndex, jrPc
  );
endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, fetches one word per request from instruction
// memory, presents it to decode and picks the next PC when decode accepts.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic         clk,
  input  logic         reset,
  fetch_seq_if.master  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Highest word-aligned PC that still maps into instruction memory.
  localparam logic [31:0] PC_LAST = RESET_PC + (32'd4 << IM_AW) - 32'd4;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] pc4;
  logic [31:0] target;
  logic        target_ok;

  assign pc4 = pc_q + 32'd4;

  // jr beats jal beats branch beats sequential.
  always_comb begin
    target = pc4;
    if (bus.jrSel) begin
      target = bus.jrPc;
    end else if (bus.jalSel) begin
      target = {pc4[31:28], bus.jalIndex, 2'b00};
    end else if (bus.branchSel) begin
      target = pc4 + {bus.pcOffset[29:0], 2'b00};
    end
  end

  assign target_ok = (target[1:0] == 2'b00) && (target >= RESET_PC) && (target <= PC_LAST);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    instr_nxt = instr_q;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (bus.imAck) begin
          instr_nxt = bus.imRd;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.instrReady) begin
          // The illegal target is still latched so the faulting PC is visible.
          pc_nxt    = target;
          state_nxt = target_ok ? REQ : FAULT;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      instr_q <= instr_nxt;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  assign bus.imReq      = (state == REQ);
  assign bus.instrValid = (state == HOLD);
  assign bus.fault      = (state == FAULT);
  assign bus.imAddr     = pc_q[IM_AW+1:2] - RESET_PC[IM_AW+1:2];
  assign bus.instr      = instr_q;
  assign bus.pc         = pc_q;
  assign bus.pc4        = pc4;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed and random fetch traffic, expected instructions
// queued by the driver and checked by an independent monitor.
module tb_fetch_seq;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IM_AW    = 12;
  localparam longint      PC_END   = longint'(RESET_PC) + 4 * (longint'(1) << IM_AW);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_seq_if #(.IM_AW(IM_AW)) bus ();

  fetch_seq #(.RESET_PC(RESET_PC), .IM_AW(IM_AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  bit          model_faulted;
  bit          first_after_reset;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic jr,
                                             input logic jal, input logic br,
                                             input logic [31:0] jrpc, input logic [25:0] idx,
                                             input logic [31:0] off);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (jr)  return jrpc;
    if (jal) return (seq & 32'hF000_0000) + 32'(idx) * 32'd4;
    if (br)  return seq + off * 32'd4;
    return seq;
  endfunction

  function automatic bit model_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= RESET_PC) && (longint'(a) < PC_END);
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] p);
    return (p - RESET_PC) / 4;
  endfunction

  // ---------------- monitor ----------------
  logic [63:0] cur_exp = '0;
  bit          prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.instrValid === 1'b1) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got instrValid=1 with pc %h, expected no pending instruction", bus.pc);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      check32("mon_pc", bus.pc, cur_exp[63:32]);
      check32("mon_instr", bus.instr, cur_exp[31:0]);
    end
    prev_valid = (bus.instrValid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    bus.branchSel = 1'($urandom_range(0, 1));
    bus.jalSel    = 1'($urandom_range(0, 1));
    bus.jrSel     = 1'($urandom_range(0, 1));
    bus.pcOffset  = $urandom;
    bus.jalIndex  = 26'($urandom);
    bus.jrPc      = $urandom;
  endtask

  task automatic reset_dut();
    bus.imAck      = 1'b0;
    bus.instrReady = 1'b0;
    reset = 1'b0;
    #1;
    check1("rst_imReq", bus.imReq, 1'b0);
    check1("rst_instrValid", bus.instrValid, 1'b0);
    check1("rst_fault", bus.fault, 1'b0);
    check32("rst_pc", bus.pc, RESET_PC);
    check32("rst_pc4", bus.pc4, RESET_PC + 32'd4);
    check32("rst_instr", bus.instr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check1("rst_hold_imReq", bus.imReq, 1'b0);
    reset             = 1'b1;
    model_pc          = RESET_PC;
    model_faulted     = 1'b0;
    first_after_reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic fetch_one(input int ack_dly, input int rdy_dly, input logic [31:0] data,
                           input logic jr, input logic jal, input logic br,
                           input logic [31:0] jrpc, input logic [25:0] idx,
                           input logic [31:0] off, input bit pulse_br);
    int          waited;
    logic [31:0] nxt;
    waited = 0;
    while (bus.imReq !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.imReq !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: got imReq=%b after %0d cycles, expected 1", bus.imReq, waited);
      model_faulted = 1'b1;
      return;
    end
    if (first_after_reset) check32("first_req_latency", waited, 1);
    else                   check32("req_latency", waited, 0);
    first_after_reset = 1'b0;
    check32("imAddr", 32'(bus.imAddr), model_addr(model_pc));
    check32("pc_req", bus.pc, model_pc);
    check32("pc4_req", bus.pc4, model_pc + 32'd4);

    for (int i = 0; i < ack_dly; i++) begin
      bus.imAck      = 1'b0;
      bus.instrReady = 1'($urandom_range(0, 1));
      scramble();
      if (pulse_br) bus.branchSel = 1'b1;
      @(negedge clk);
      check1("req_held", bus.imReq, 1'b1);
      check32("imAddr_held", 32'(bus.imAddr), model_addr(model_pc));
      check1("no_valid_in_req", bus.instrValid, 1'b0);
    end

    bus.imAck      = 1'b1;
    bus.imRd       = data;
    bus.instrReady = 1'($urandom_range(0, 1));
    exp_q.push_back({model_pc, data});
    scramble();
    if (pulse_br) bus.branchSel = 1'b1;
    @(negedge clk);
    bus.imAck = 1'($urandom_range(0, 1));
    bus.imRd  = $urandom;
    check1("req_drop", bus.imReq, 1'b0);

    for (int i = 0; i < rdy_dly; i++) begin
      bus.instrReady = 1'b0;
      scramble();
      @(negedge clk);
      bus.imAck = 1'($urandom_range(0, 1));
      check1("valid_held", bus.instrValid, 1'b1);
    end

    bus.instrReady = 1'b1;
    bus.jrSel      = jr;
    bus.jalSel     = jal;
    bus.branchSel  = br;
    bus.jrPc       = jrpc;
    bus.jalIndex   = idx;
    bus.pcOffset   = off;
    nxt = model_next(model_pc, jr, jal, br, jrpc, idx, off);
    @(negedge clk);
    bus.instrReady = 1'b0;
    bus.imAck      = 1'b0;
    scramble();
    check1("valid_fall", bus.instrValid, 1'b0);
    check32("pc_next", bus.pc, nxt);
    if (model_legal(nxt)) begin
      check1("fault_clear", bus.fault, 1'b0);
      model_pc = nxt;
    end else begin
      check1("fault_rise", bus.fault, 1'b1);
      check1("fault_imReq", bus.imReq, 1'b0);
      for (int i = 0; i < 3; i++) begin
        bus.imAck      = 1'b1;
        bus.instrReady = 1'b1;
        scramble();
        @(negedge clk);
        check1("fault_sticky", bus.fault, 1'b1);
        check1("fault_no_req", bus.imReq, 1'b0);
        check1("fault_no_valid", bus.instrValid, 1'b0);
        check32("fault_pc", bus.pc, nxt);
      end
      bus.imAck      = 1'b0;
      bus.instrReady = 1'b0;
      model_pc       = nxt;
      model_faulted  = 1'b1;
    end
  endtask

  task automatic seq_one(input int ack_dly, input int rdy_dly, input logic [31:0] data);
    fetch_one(ack_dly, rdy_dly, data, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0);
  endtask

  task automatic jr_one(input logic [31:0] target);
    fetch_one(0, 0, $urandom, 1'b1, 1'b0, 1'b0, target, 26'h0, 32'h0, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] jt;
    logic [25:0] ji;
    logic [31:0] bo;
    bus.imAck      = 1'b0;
    bus.imRd       = '0;
    bus.instrReady = 1'b0;
    scramble();
    #2;
    reset_dut();

    // Sequential fetch at full rate, then a stalled one.
    seq_one(0, 0, 32'h0000_0000);
    seq_one(0, 0, 32'h0000_0000);
    seq_one(0, 0, 32'h0000_0000);
    seq_one(3, 2, $urandom);

    // Priority at pc 0x3010.
    check32("pc_at_3010", model_pc, 32'h0000_3010);
    fetch_one(0, 0, $urandom, 1'b1, 1'b1, 1'b1, 32'h0000_3100, 26'h0000C40, 32'hFFFF_FFFE, 1'b0);
    jr_one(32'h0000_3010);
    fetch_one(0, 1, $urandom, 1'b0, 1'b1, 1'b0, 32'h0, 26'h0000C40, 32'h0, 1'b0);
    check32("jal_target", bus.pc, 32'h0000_3100);
    jr_one(32'h0000_3010);
    fetch_one(1, 0, $urandom, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'hFFFF_FFFE, 1'b0);
    check32("branch_target", bus.pc, 32'h0000_300C);

    // branchSel pulsed only while requesting: sequential path wins.
    fetch_one(2, 1, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h4, 1'b1);
    check32("pulse_ignored", bus.pc, 32'h0000_3010);

    // Faults and the top-of-memory boundary.
    jr_one(32'h0000_3102);
    reset_dut();
    seq_one(0, 0, $urandom);
    jr_one(32'h0000_7000);
    reset_dut();
    jr_one(32'h0000_6FFC);
    check32("imAddr_top", 32'(bus.imAddr), 32'h0000_0FFF);
    seq_one(0, 0, $urandom);
    check1("fault_past_end", bus.fault, 1'b1);
    reset_dut();

    // Reset while a request is outstanding; a late ack in IDLE is ignored.
    @(negedge clk);
    check1("mid_req_up", bus.imReq, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check1("mid_req_async_drop", bus.imReq, 1'b0);
    check1("mid_req_async_valid", bus.instrValid, 1'b0);
    @(negedge clk);
    reset     = 1'b1;
    bus.imAck = 1'b1;
    bus.imRd  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.imAck = 1'b0;
    check1("idle_ack_ignored", bus.instrValid, 1'b0);
    check1("restart_req", bus.imReq, 1'b1);
    check1("restart_fault", bus.fault, 1'b0);
    model_pc          = RESET_PC;
    model_faulted     = 1'b0;
    first_after_reset = 1'b0;
    exp_q.delete();
    seq_one(0, 0, $urandom);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if (model_faulted) reset_dut();
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0:       jt = RESET_PC - 32'd4;
          1:       jt = 32'(PC_END);
          2:       jt = RESET_PC + 32'd4 * $urandom_range(0, 4095) + 32'($urandom_range(1, 3));
          default: jt = $urandom;
        endcase
      end else begin
        jt = RESET_PC + 32'd4 * $urandom_range(0, 4095);
      end
      ji = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'($urandom_range(32'hC00, 32'h1BFF));
      bo = 32'($urandom_range(0, 16)) - 32'd8;
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) == 0), jt, ji, bo, 1'($urandom_range(0, 4) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
